// File: rtl/timer_arbiter_pkg.sv
// Shared types for the timer arbiter slice.
// FSM encoding and owner-index sizing.
package timer_arbiter_pkg;

  localparam int unsigned NUM_REQ_DEFAULT = 4;
  localparam int unsigned OWNER_W = $clog2(NUM_REQ_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int unsigned owner_width(
    input int unsigned n
  );
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expired while the count sits at zero.
// Holds at zero rather than wrapping.
module cycle_timer #(
  parameter int unsigned BIT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 load_count,
  input  logic [BIT_WIDTH-1:0] count,
  output logic                 expired
);

  logic [BIT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      if (load_count) begin
        cnt_d = count;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin sharing of one cycle_timer among several clients.
// grant/done decode from registered state only.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned BIT_WIDTH      = 16
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                tick,
  input  logic [NUM_REQUESTERS-1:0]           request,
  input  logic [NUM_REQUESTERS*BIT_WIDTH-1:0] request_count,
  output logic [NUM_REQUESTERS-1:0]           grant,
  output logic [NUM_REQUESTERS-1:0]           done,
  output logic                                busy
);

  localparam int unsigned IDX_W = owner_width(NUM_REQUESTERS);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQUESTERS - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [BIT_WIDTH-1:0] count_q, count_d;
  logic [IDX_W-1:0]     pick;
  logic                 tmr_en;
  logic                 tmr_load;
  logic                 tmr_expired;
  logic [NUM_REQUESTERS-1:0] owner_oh;

  // First set bit after ptr, wrapping; descending loop keeps the nearest.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_REQUESTERS-1:0] req,
    input logic [IDX_W-1:0]          ptr
  );
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] k;
    int               idx;
    sel = '0;
    for (int i = NUM_REQUESTERS; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NUM_REQUESTERS;
      k   = IDX_W'(idx);
      if (req[k]) sel = k;
    end
    return sel;
  endfunction

  assign pick = rr_pick(request, ptr_q);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    tmr_en   = 1'b0;
    tmr_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|request) begin
          owner_d = pick;
          count_d = request_count[pick*BIT_WIDTH +: BIT_WIDTH];
          state_d = LOAD;
        end
      end
      LOAD: begin
        tmr_en   = 1'b1;
        tmr_load = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        tmr_en = tick;
        if (!request[owner_q]) begin
          state_d = IDLE;
        end else if (tmr_expired) begin
          state_d = DONE;
        end
      end
      DONE: begin
        ptr_d   = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= PTR_RST;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  cycle_timer #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (tmr_en),
    .load_count (tmr_load),
    .count      (count_q),
    .expired    (tmr_expired)
  );

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  assign busy  = (state_q != IDLE);
  assign grant = busy ? owner_oh : '0;
  assign done  = (state_q == DONE) ? owner_oh : '0;

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: vector tables, corner sequences,
// and random traffic against a transaction-level model.
module tb_timer_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           tick = 1'b1;
  logic [N-1:0]   request = '0;
  logic [N*W-1:0] request_count = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;

  always #5 clock = ~clock;

  timer_arbiter #(
    .NUM_REQUESTERS (N),
    .BIT_WIDTH      (W)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .tick          (tick),
    .request       (request),
    .request_count (request_count),
    .grant         (grant),
    .done          (done),
    .busy          (busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: who holds the timer, ticks still owed, last finisher.
  int m_own;
  int m_left;
  int m_last;
  bit m_first;
  bit m_pulse;

  function automatic void m_reset();
    m_own   = -1;
    m_left  = 0;
    m_last  = N - 1;
    m_first = 0;
    m_pulse = 0;
  endfunction

  function automatic bit req_bit(input int k);
    return ((request >> k) & 1) != 0;
  endfunction

  function automatic void m_step();
    bit found;
    int k;
    if (m_own < 0) begin
      found = 0;
      for (int i = 1; i <= N; i++) begin
        k = (m_last + i) % N;
        if (!found && req_bit(k)) begin
          found   = 1;
          m_own   = k;
          m_left  = int'(W'(request_count >> (k * W)));
          m_first = 1;
        end
      end
    end else if (m_pulse) begin
      m_last  = m_own;
      m_own   = -1;
      m_pulse = 0;
    end else if (m_first) begin
      m_first = 0;
    end else if (!req_bit(m_own)) begin
      m_own = -1;
    end else if (m_left == 0) begin
      m_pulse = 1;
    end else if (tick) begin
      m_left = m_left - 1;
    end
  endfunction

  function automatic logic [N-1:0] m_grant();
    return (m_own >= 0) ? (N'(1) << m_own) : '0;
  endfunction

  function automatic logic [N-1:0] m_done();
    return (m_own >= 0 && m_pulse) ? (N'(1) << m_own) : '0;
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h",
               name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    if (!reset_n) m_reset();
    else m_step();
    #1;
    cyc++;
    check("model", {7'd0, grant, done, busy},
          {7'd0, m_grant(), m_done(), (m_own >= 0)});
  endtask

  task automatic set_all_counts(input logic [W-1:0] c);
    request_count = {N{c}};
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [W-1:0] cnt;
    logic         tk;
    logic [N-1:0] g;
    logic [N-1:0] d;
    logic         b;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input logic [N-1:0] req, input logic [W-1:0] c,
                              input logic [N-1:0] g, input logic [N-1:0] d,
                              input logic b);
    vec_t v;
    v.req = req; v.cnt = c; v.tk = 1'b1;
    v.g = g; v.d = d; v.b = b;
    tv.push_back(v);
  endfunction

  initial begin
    int gstart;
    int ndone;
    int gcnt;
    int t;
    int first_done;
    bit d1_seen;
    logic [N-1:0] prev_g;
    logic [N-1:0] order[$];

    m_reset();
    reset_n = 1'b0;
    repeat (2) step();
    check("reset_state", {7'd0, grant, done, busy}, 16'd0);
    reset_n = 1'b1;
    step();
    check("idle_after_reset", {7'd0, grant, done, busy}, 16'd0);

    // Client 0, count 5: grant t+1, done t+8, idle t+9.
    for (int i = 0; i < 7; i++) add(4'b0001, 16'd5, 4'b0001, 4'b0000, 1'b1);
    add(4'b0001, 16'd5, 4'b0001, 4'b0001, 1'b1);
    add(4'b0000, 16'd5, 4'b0000, 4'b0000, 1'b0);
    add(4'b0000, 16'd5, 4'b0000, 4'b0000, 1'b0);
    // Client 2, count 0: done at t+3, single pulse.
    add(4'b0100, 16'd0, 4'b0100, 4'b0000, 1'b1);
    add(4'b0100, 16'd0, 4'b0100, 4'b0000, 1'b1);
    add(4'b0100, 16'd0, 4'b0100, 4'b0100, 1'b1);
    add(4'b0000, 16'd0, 4'b0000, 4'b0000, 1'b0);
    add(4'b0000, 16'd0, 4'b0000, 4'b0000, 1'b0);
    foreach (tv[i]) begin
      request = tv[i].req;
      set_all_counts(tv[i].cnt);
      tick = tv[i].tk;
      step();
      check($sformatf("vec%0d", i), {7'd0, grant, done, busy},
            {7'd0, tv[i].g, tv[i].d, tv[i].b});
    end

    // Clients 0 and 2 held, count 2: alternate grants.
    request = 4'b0101;
    set_all_counts(16'd2);
    ndone = 0;
    gstart = 0;
    prev_g = '0;
    for (int i = 0; i < 60 && ndone < 4; i++) begin
      step();
      if (grant != 0 && prev_g == 0) begin
        order.push_back(grant);
        gstart = cyc;
      end
      if (done != 0) begin
        ndone++;
        check("t3_done_lat", 16'(cyc - gstart), 16'd4);
        check("t3_done_owner", {12'd0, done}, {12'd0, grant});
      end
      prev_g = grant;
    end
    request = '0;
    check("t3_ndone", 16'(ndone), 16'd4);
    check("t3_order", {order.size() > 0 ? order[0] : 4'h0,
                       order.size() > 1 ? order[1] : 4'h0,
                       order.size() > 2 ? order[2] : 4'h0,
                       order.size() > 3 ? order[3] : 4'h0}, 16'h1414);
    repeat (2) step();

    // Sparse tick, count 3 on client 1.
    request = 4'b0010;
    set_all_counts(16'd3);
    gcnt = 0;
    ndone = 0;
    for (int i = 0; i < 80 && ndone == 0; i++) begin
      tick = (i % 4 == 3);
      step();
      if (grant != 0) gcnt++;
      if (done != 0) begin
        ndone++;
        check("t4_done", {12'd0, done}, 16'h0002);
      end
    end
    check("t4_seen_done", 16'(ndone), 16'd1);
    check("t4_run_len_ok", 16'((gcnt - 2) >= 9 && (gcnt - 2) <= 15), 16'd1);
    request = '0;
    tick = 1'b1;
    repeat (2) step();

    // Cancel: client 1 drops mid-run, pending client 3 follows.
    request_count = '0;
    request_count[1*W +: W] = 16'd10;
    request_count[3*W +: W] = 16'd4;
    request = 4'b0010;
    d1_seen = 0;
    repeat (5) step();
    request = 4'b1010;
    repeat (2) step();
    check("t5_running", {12'd0, grant}, 16'h0002);
    request = 4'b1000;
    step();
    check("t5_idle", {11'd0, grant, busy}, 16'd0);
    step();
    check("t5_grant3", {12'd0, grant}, 16'h0008);
    gstart = cyc;
    ndone = 0;
    for (int i = 0; i < 20 && ndone == 0; i++) begin
      step();
      if (done[1]) d1_seen = 1;
      if (done != 0) begin
        ndone++;
        check("t5_done3_lat", 16'(cyc - gstart), 16'd6);
        check("t5_done3", {12'd0, done}, 16'h0008);
      end
    end
    check("t5_no_done1", 16'(d1_seen), 16'd0);
    check("t5_seen_done", 16'(ndone), 16'd1);
    request = '0;
    repeat (2) step();

    // Async reset during RUN, then count 7 on client 0.
    set_all_counts(16'd20);
    request = 4'b0001;
    repeat (6) step();
    check("t6_busy_pre", {15'd0, busy}, 16'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_async", {7'd0, grant, done, busy}, 16'd0);
    set_all_counts(16'd7);
    repeat (2) step();
    reset_n = 1'b1;
    first_done = 0;
    t = 0;
    for (int i = 1; i <= 20 && first_done == 0; i++) begin
      step();
      if (i == 1) check("t6_first_grant", {12'd0, grant}, 16'h0001);
      if (done != 0) begin
        first_done = i;
        check("t6_done_owner", {12'd0, done}, 16'h0001);
      end
    end
    check("t6_done_lat", 16'(first_done), 16'd10);
    request = '0;
    repeat (2) step();

    // Random traffic with occasional async reset.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) begin
        if (request[k]) begin
          if (done[k] && $urandom_range(0, 1) == 0) request[k] = 1'b0;
          else if ($urandom_range(0, 31) == 0) request[k] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          request[k] = 1'b1;
        end
        request_count[k*W +: W] = W'($urandom_range(0, 7));
      end
      tick = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        #1;
        check("rand_async", {7'd0, grant, done, busy}, 16'd0);
        step();
        reset_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
